// File: rtl/pad_uart_rx.sv
// 8N1 UART receiver for a pad input: two-flop synchronizer, mid-bit sampling FSM
// and a small receive FIFO with overrun and framing error pulses.
module pad_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       busy_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          sync1_q, rx_s_q, rx_prev_q;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop, full, wr_en;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          // A line that is high again at mid start bit was only a glitch
          if (!rx_s_q) begin
            state_d = DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          state_d     = IDLE;
          cnt_d       = '0;
          push        = rx_s_q;
          frame_err_d = !rx_s_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO still accepts a byte when the head leaves on the same cycle
  always_comb begin
    pop       = (count_q != '0) && ready_i;
    full      = (count_q == FULL_CNT);
    wr_en     = push && (!full || pop);
    overrun_d = push && full && !pop;
    mem_d     = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = shift_q;
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      sync1_q     <= rx_i;
      rx_s_q      <= sync1_q;
      rx_prev_q   <= rx_s_q;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
    end
  end

  assign valid_o     = (count_q != '0);
  assign data_o      = valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign busy_o      = (state_q != IDLE);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_pad_uart_rx.sv
// Bench for pad_uart_rx: directed frames plus randomized frame bursts checked
// against a queue model of the receive FIFO.
module tb_pad_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, rx_i, ready_i;
  logic [7:0] data_o;
  logic       valid_o, busy_o, frame_err_o, overrun_o;

  int total, passed;
  logic [200:0] valid_h, ferr_h, ovr_h, busy_h;
  logic [7:0] got[$];
  logic [7:0] model[$];

  pad_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx_i(rx_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .busy_o(busy_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  // Entered and left at 1 time unit after a rising edge; history index n is
  // the output value just after the n-th edge counted from the start-bit drop.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit pop_at_push,
                            input int abort_at);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    valid_h = '0; ferr_h = '0; ovr_h = '0; busy_h = '0;
    valid_h[0] = valid_o;
    rx_i = bits[0];
    for (int n = 1; n <= 10 * CPB; n++) begin
      @(posedge clk); #1;
      valid_h[n] = valid_o; ferr_h[n] = frame_err_o;
      ovr_h[n] = overrun_o; busy_h[n] = busy_o;
      if (n == abort_at) begin
        rst = 1'b1;
        return;
      end
      if (pop_at_push && n == 154) ready_i = 1'b1;
      if (pop_at_push && n == 155) ready_i = 1'b0;
      if (n < 10 * CPB) rx_i = bits[n / CPB];
    end
    rx_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    got.delete();
    ready_i = 1'b1;
    for (int i = 0; i < 3 * DEPTH && valid_o; i++) begin
      got.push_back(data_o);
      @(posedge clk); #1;
    end
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_i = 1'b1; ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", valid_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); else passed++;
    total++; if (frame_err_o !== 1'b0) $display("[TB] FAIL reset_ferr: got %b expected 0", frame_err_o); else passed++;
    total++; if (overrun_o !== 1'b0) $display("[TB] FAIL reset_ovr: got %b expected 0", overrun_o); else passed++;
    total++; if (data_o !== 8'h00) $display("[TB] FAIL reset_data: got %h expected 00", data_o); else passed++;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single_byte();
    send_frame(8'hA5, 1'b1, 1'b0, 0);
    total++; if (valid_h[154] !== 1'b0) $display("[TB] FAIL a5_valid_early: got %b expected 0", valid_h[154]); else passed++;
    total++; if (valid_h[155] !== 1'b1) $display("[TB] FAIL a5_valid_rise: got %b expected 1", valid_h[155]); else passed++;
    total++; if (busy_h[154] !== 1'b1 || busy_h[155] !== 1'b0)
      $display("[TB] FAIL a5_busy_end: got %b%b expected 10", busy_h[154], busy_h[155]); else passed++;
    total++; if ($countones(ferr_h) != 0) $display("[TB] FAIL a5_ferr: got %0d pulses expected 0", $countones(ferr_h)); else passed++;
    total++; if (data_o !== 8'hA5) $display("[TB] FAIL a5_data: got %h expected a5", data_o); else passed++;
    drain();
    total++; if (got.size() != 1 || got[0] !== 8'hA5) $display("[TB] FAIL a5_drain: got %0d bytes expected 1 (a5)", got.size()); else passed++;
    total++; if (valid_o !== 1'b0) $display("[TB] FAIL a5_empty: got %b expected 0", valid_o); else passed++;
  endtask

  task automatic test_glitch();
    busy_h = '0; valid_h = '0;
    rx_i = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      busy_h[n] = busy_o; valid_h[n] = valid_o;
      if (n == 4) rx_i = 1'b1;
    end
    total++; if ($countones(busy_h) != 8) $display("[TB] FAIL glitch_busy_len: got %0d expected 8", $countones(busy_h)); else passed++;
    total++; if (busy_h[2] !== 1'b0 || busy_h[3] !== 1'b1 || busy_h[10] !== 1'b1 || busy_h[11] !== 1'b0)
      $display("[TB] FAIL glitch_busy_window: got %b%b%b%b expected 0110", busy_h[2], busy_h[3], busy_h[10], busy_h[11]); else passed++;
    total++; if ($countones(valid_h) != 0) $display("[TB] FAIL glitch_valid: got %0d expected 0", $countones(valid_h)); else passed++;
  endtask

  task automatic test_frame_error();
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    total++; if (ferr_h[155] !== 1'b1) $display("[TB] FAIL ferr_pulse: got %b expected 1", ferr_h[155]); else passed++;
    total++; if ($countones(ferr_h) != 1) $display("[TB] FAIL ferr_width: got %0d expected 1", $countones(ferr_h)); else passed++;
    total++; if ($countones(valid_h) != 0) $display("[TB] FAIL ferr_valid: got %0d expected 0", $countones(valid_h)); else passed++;
    send_frame(8'h11, 1'b1, 1'b0, 0);
    total++; if ($countones(ferr_h) != 0) $display("[TB] FAIL ferr_next_err: got %0d expected 0", $countones(ferr_h)); else passed++;
    drain();
    total++; if (got.size() != 1 || got[0] !== 8'h11) $display("[TB] FAIL ferr_next_data: got %0d bytes expected 1 (11)", got.size()); else passed++;
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 1'b0, 0);
      total++;
      if ($countones(ovr_h) != (i == 5 ? 1 : 0) || ovr_h[155] !== (i == 5))
        $display("[TB] FAIL ovr_pulse_%0d: got %0d pulses expected %0d", i, $countones(ovr_h), (i == 5 ? 1 : 0));
      else passed++;
    end
    drain();
    total++; if (got.size() != 4) $display("[TB] FAIL ovr_count: got %0d expected 4", got.size()); else passed++;
    for (int i = 0; i < got.size() && i < 4; i++) begin
      total++; if (got[i] !== 8'(i + 1)) $display("[TB] FAIL ovr_data_%0d: got %h expected %h", i, got[i], 8'(i + 1)); else passed++;
    end
    total++; if (valid_o !== 1'b0) $display("[TB] FAIL ovr_empty: got %b expected 0", valid_o); else passed++;
  endtask

  task automatic test_full_pop();
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0, 0);
    send_frame(8'h05, 1'b1, 1'b1, 0);
    total++; if ($countones(ovr_h) != 0) $display("[TB] FAIL fullpop_ovr: got %0d expected 0", $countones(ovr_h)); else passed++;
    total++; if (valid_h[156] !== 1'b1) $display("[TB] FAIL fullpop_valid: got %b expected 1", valid_h[156]); else passed++;
    drain();
    total++; if (got.size() != 4) $display("[TB] FAIL fullpop_count: got %0d expected 4", got.size()); else passed++;
    for (int i = 0; i < got.size() && i < 4; i++) begin
      total++; if (got[i] !== 8'(i + 2)) $display("[TB] FAIL fullpop_data_%0d: got %h expected %h", i, got[i], 8'(i + 2)); else passed++;
    end
  endtask

  task automatic test_one_entry();
    send_frame(8'h11, 1'b1, 1'b0, 0);
    send_frame(8'h22, 1'b1, 1'b1, 0);
    total++; if (valid_h[155] !== 1'b1 || valid_h[156] !== 1'b1)
      $display("[TB] FAIL one_valid: got %b%b expected 11", valid_h[155], valid_h[156]); else passed++;
    total++; if (data_o !== 8'h22) $display("[TB] FAIL one_data: got %h expected 22", data_o); else passed++;
    drain();
    total++; if (got.size() != 1 || got[0] !== 8'h22) $display("[TB] FAIL one_drain: got %0d bytes expected 1 (22)", got.size()); else passed++;
  endtask

  task automatic test_reset_midframe();
    send_frame(8'hA5, 1'b1, 1'b0, 0);
    send_frame(8'h5A, 1'b1, 1'b0, 88);
    #1;
    total++; if (valid_o !== 1'b0 || data_o !== 8'h00) $display("[TB] FAIL mid_rst_fifo: got %b/%h expected 0/00", valid_o, data_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("[TB] FAIL mid_rst_busy: got %b expected 0", busy_o); else passed++;
    total++; if (frame_err_o !== 1'b0 || overrun_o !== 1'b0)
      $display("[TB] FAIL mid_rst_pulses: got %b%b expected 00", frame_err_o, overrun_o); else passed++;
    rx_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    total++; if (valid_o !== 1'b0 || busy_o !== 1'b0) $display("[TB] FAIL mid_rst_after: got %b%b expected 00", valid_o, busy_o); else passed++;
    send_frame(8'h7E, 1'b1, 1'b0, 0);
    drain();
    total++; if (got.size() != 1 || got[0] !== 8'h7E) $display("[TB] FAIL mid_rst_next: got %0d bytes expected 1 (7e)", got.size()); else passed++;
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit bad, exp_ovr;
    int nf;
    model.delete();
    for (int r = 0; r < 6; r++) begin
      nf = $urandom_range(1, 6);
      for (int f = 0; f < nf; f++) begin
        b = 8'($urandom);
        bad = ($urandom_range(0, 4) == 0);
        exp_ovr = 1'b0;
        send_frame(b, !bad, 1'b0, 0);
        if (!bad) begin
          if (model.size() == DEPTH) exp_ovr = 1'b1;
          else model.push_back(b);
        end
        total++; if ($countones(ferr_h) != int'(bad)) $display("[TB] FAIL rnd_ferr_%0d_%0d: got %0d expected %0d", r, f, $countones(ferr_h), int'(bad)); else passed++;
        total++; if ($countones(ovr_h) != int'(exp_ovr)) $display("[TB] FAIL rnd_ovr_%0d_%0d: got %0d expected %0d", r, f, $countones(ovr_h), int'(exp_ovr)); else passed++;
        total++; if (valid_h[155] !== (model.size() != 0)) $display("[TB] FAIL rnd_valid_%0d_%0d: got %b expected %b", r, f, valid_h[155], (model.size() != 0)); else passed++;
      end
      drain();
      total++; if (got.size() != model.size()) $display("[TB] FAIL rnd_count_%0d: got %0d expected %0d", r, got.size(), model.size()); else passed++;
      for (int i = 0; i < got.size() && i < model.size(); i++) begin
        total++; if (got[i] !== model[i]) $display("[TB] FAIL rnd_data_%0d_%0d: got %h expected %h", r, i, got[i], model[i]); else passed++;
      end
      model.delete();
    end
  endtask

  initial begin
    total = 0; passed = 0;
    rst = 1'b1; rx_i = 1'b1; ready_i = 1'b0;
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_full_pop();
    test_one_entry();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pad_uart_rx.md
PAD_UART_RX -- requirements
Module: pad_uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 4..65535, even values only.
REQ-002 Parameter FIFO_DEPTH, default 4: receive FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx_i  input  1  serial line from pad din; idle high; asynchronous to clk.
REQ-006 data_o  output  8  byte at FIFO head; valid only when valid_o=1.
REQ-007 valid_o  output  1  FIFO non-empty.
REQ-008 ready_i  input  1  consumer accepts head when valid_o&ready_i.
REQ-009 busy_o  output  1  high in any state other than IDLE.
REQ-010 frame_err_o  output  1  one-cycle pulse on bad stop bit.
REQ-011 overrun_o  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-012 rx_i passes through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value rx_s; rx_s lags rx_i by 2 cycles.
REQ-013 FSM states IDLE, START, DATA, STOP; bit counter cnt (16 bits) and bit index idx (3 bits).
REQ-014 IDLE: on rx_s falling edge (previous rx_s=1, current 0) -> START, cnt cleared.
REQ-015 START: after CLKS_PER_BIT/2 cycles, sample rx_s; 0 -> DATA with cnt and idx cleared; 1 -> IDLE (glitch rejected, nothing pushed, no error).
REQ-016 DATA: sample rx_s every CLKS_PER_BIT cycles; bits shifted in LSB first; after idx=7 -> STOP.
REQ-017 STOP: sample rx_s after CLKS_PER_BIT cycles; 1 -> push shift register to FIFO; 0 -> pulse frame_err_o, discard byte; both -> IDLE.
REQ-018 After a frame error, IDLE accepts no new start until rx_s has been observed high (falling-edge rule of REQ-014 enforces this).
REQ-019 Push is visible as valid_o=1 on the cycle after the stop-bit sample cycle.
REQ-020 Pop occurs on any cycle with valid_o&ready_i; data_o advances to the next entry on the following cycle.
REQ-021 Push while full with no simultaneous pop: byte dropped, FIFO unchanged, overrun_o pulses for one cycle.
REQ-022 Push and pop on the same cycle while full: both take effect; no overrun; occupancy unchanged.
REQ-023 Push and pop on the same cycle while holding 1 entry: valid_o stays 1; data_o shows the new byte next cycle.
REQ-024 ready_i while empty has no effect; read/write pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
REQ-025 frame_err_o and overrun_o never assert in the same cycle as a successful push.

Reset
REQ-026 rst asserted: FSM=IDLE, cnt=0, idx=0, shift register=0, FIFO empty, synchronizer flops=1; valid_o=0, busy_o=0, frame_err_o=0, overrun_o=0, data_o=0.
REQ-027 rst asserted mid-frame aborts the frame with no push and no error pulse; after release, the first falling edge of rx_s starts a new frame.
REQ-028 Outputs respond to rst asynchronously; release is taken on a clk edge.

Verification
REQ-029 CLKS_PER_BIT=16, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1), ready_i=0 -> valid_o=1, data_o=8'hA5 one cycle after stop sample; frame_err_o=0.
REQ-030 rx_i low for 4 cycles then high -> START returns to IDLE; valid_o stays 0; busy_o high for 8 cycles, then 0.
REQ-031 Send 0x3C with stop bit 0 -> frame_err_o one-cycle pulse; valid_o stays 0; next frame 0x11 received correctly.
REQ-032 FIFO_DEPTH=4, ready_i=0, send 0x01..0x05 -> 5th byte dropped, overrun_o one pulse; then ready_i=1 pops 0x01,0x02,0x03,0x04 in order, after which valid_o=0.
REQ-033 FIFO full and ready_i=1 on the push cycle of 0x05 -> no overrun; pops yield 0x02..0x05.
REQ-034 rst pulsed during bit 4 of a frame -> all outputs at reset values; no byte is pushed; a following 0x7E frame is received correctly.
